// File: rtl/icache_responder.sv
// Read-only direct-mapped instruction cache: CPU fetch responder with 256-bit line-fill initiator.
// Optional hit/miss counters are enabled with `define ICACHE_PERF_CNT_EN.
module icache_responder #(
   parameter int unsigned SETS = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [31:0]   imem_addr,
   input  logic [3:0]    imem_rmask,
   output logic [31:0]   imem_rdata,
   output logic          imem_resp,
   input  logic          flush,
   output logic [31:0]   bmem_addr,
   output logic          bmem_read,
   input  logic [255:0]  bmem_rdata,
   input  logic          bmem_resp
`ifdef ICACHE_PERF_CNT_EN
   ,
   output logic [31:0]   hit_count,
   output logic [31:0]   miss_count
`endif
);

   localparam int unsigned IDX_W = $clog2(SETS);
   localparam int unsigned TAG_W = 27 - IDX_W;

   typedef enum logic [1:0] {IDLE, COMPARE, FILL, RESP} state_t;

   state_t              state_q;
   logic [SETS-1:0]     valid_q;
   logic [TAG_W-1:0]    tag_q  [SETS];
   logic [255:0]        data_q [SETS];
   logic [31:2]         req_addr_q;
   logic                cmp_hit_q;
   logic                flush_pend_q;
   logic                resp_q;
   logic [31:0]         rdata_q;
   logic                bmem_read_q;
   logic [31:0]         bmem_addr_q;

   logic [IDX_W-1:0]    lk_idx_c;
   logic                lk_hit_c;
   logic [31:0]         lk_word_c;
   logic [IDX_W-1:0]    req_idx_c;
   logic [31:0]         fill_word_c;
   logic                accept_c;
   logic                fill_done_c;
   logic                unused_addr_bits;

   assign unused_addr_bits = ^imem_addr[1:0];

   // Lookup of the incoming fetch; a flush in the same cycle hides all lines from it.
   always_comb begin
      lk_idx_c  = imem_addr[5 +: IDX_W];
      lk_hit_c  = valid_q[lk_idx_c] && (tag_q[lk_idx_c] == imem_addr[31 -: TAG_W]) && !flush;
      lk_word_c = data_q[lk_idx_c][{imem_addr[4:2], 5'b0} +: 32];
   end

   assign req_idx_c   = req_addr_q[5 +: IDX_W];
   assign fill_word_c = bmem_rdata[{req_addr_q[4:2], 5'b0} +: 32];
   assign fill_done_c = (state_q == FILL) && bmem_resp;
   assign accept_c    = (imem_rmask != 4'h0) &&
                        ((state_q == IDLE) || ((state_q == COMPARE) && cmp_hit_q));

   // Control FSM; the response for an accepted hit is registered at acceptance.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         valid_q      <= '0;
         req_addr_q   <= '0;
         cmp_hit_q    <= 1'b0;
         flush_pend_q <= 1'b0;
         resp_q       <= 1'b0;
         rdata_q      <= '0;
         bmem_read_q  <= 1'b0;
         bmem_addr_q  <= '0;
      end else begin
         resp_q <= 1'b0;
         if (flush) valid_q <= '0;
         if (accept_c) begin
            req_addr_q <= imem_addr[31:2];
            cmp_hit_q  <= lk_hit_c;
            resp_q     <= lk_hit_c;
            rdata_q    <= lk_word_c;
            state_q    <= COMPARE;
         end
         case (state_q)
            IDLE: ;
            COMPARE: begin
               if (!cmp_hit_q) begin
                  state_q      <= FILL;
                  bmem_read_q  <= 1'b1;
                  bmem_addr_q  <= {req_addr_q[31:5], 5'b0};
                  flush_pend_q <= 1'b0;
               end else if (!accept_c) begin
                  state_q <= IDLE;
               end
            end
            FILL: begin
               if (flush) flush_pend_q <= 1'b1;
               if (bmem_resp) begin
                  bmem_read_q <= 1'b0;
                  resp_q      <= 1'b1;
                  rdata_q     <= fill_word_c;
                  state_q     <= RESP;
                  if (!flush && !flush_pend_q) valid_q[req_idx_c] <= 1'b1;
               end
            end
            RESP: state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   // Tag and data storage are not reset; only valid bits qualify them.
   always_ff @(posedge clk) begin
      if (fill_done_c) begin
         data_q[req_idx_c] <= bmem_rdata;
         tag_q[req_idx_c]  <= req_addr_q[31 -: TAG_W];
      end
   end

   assign imem_resp  = resp_q;
   assign imem_rdata = rdata_q;
   assign bmem_read  = bmem_read_q;
   assign bmem_addr  = bmem_addr_q;

`ifdef ICACHE_PERF_CNT_EN
   logic [31:0] hit_cnt_q;
   logic [31:0] miss_cnt_q;

   // Saturating counters; flush leaves them untouched.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else if (state_q == COMPARE) begin
         if (cmp_hit_q && (hit_cnt_q != 32'hFFFF_FFFF))
            hit_cnt_q <= hit_cnt_q + 32'd1;
         if (!cmp_hit_q && (miss_cnt_q != 32'hFFFF_FFFF))
            miss_cnt_q <= miss_cnt_q + 32'd1;
      end
   end

   assign hit_count  = hit_cnt_q;
   assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache_responder.sv
// Directed self-checking bench for icache_responder (SETS=16).
module tb_icache_responder;

   logic          clk;
   logic          rst;
   logic [31:0]   imem_addr;
   logic [3:0]    imem_rmask;
   logic [31:0]   imem_rdata;
   logic          imem_resp;
   logic          flush;
   logic [31:0]   bmem_addr;
   logic          bmem_read;
   logic [255:0]  bmem_rdata;
   logic          bmem_resp;
`ifdef ICACHE_PERF_CNT_EN
   logic [31:0]   hit_count;
   logic [31:0]   miss_count;
`endif

   int tests = 0;
   int fails = 0;

   icache_responder #(.SETS(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .imem_addr  (imem_addr),
      .imem_rmask (imem_rmask),
      .imem_rdata (imem_rdata),
      .imem_resp  (imem_resp),
      .flush      (flush),
      .bmem_addr  (bmem_addr),
      .bmem_read  (bmem_read),
      .bmem_rdata (bmem_rdata),
      .bmem_resp  (bmem_resp)
`ifdef ICACHE_PERF_CNT_EN
      ,
      .hit_count  (hit_count),
      .miss_count (miss_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] wd(input logic [31:0] base, input int w);
      return {base[31:16] ^ 16'hBEEF, base[15:0] + 16'(w * 4)};
   endfunction

   function automatic logic [255:0] mk_line(input logic [31:0] base);
      logic [255:0] l;
      for (int w = 0; w < 8; w++) l[32*w +: 32] = wd(base, w);
      return l;
   endfunction

   // Request a missing address and serve its fill after two wait cycles.
   task automatic fetch_miss(input string tag, input logic [31:0] addr, input logic [255:0] line,
                             input logic [31:0] exp_word);
      imem_addr  = addr;
      imem_rmask = 4'hF;
      tick;
      flush      = 1'b0;
      chk({tag, ".cmp_resp"}, 32'(imem_resp), 32'd0);
      imem_rmask = 4'h0;
      imem_addr  = 32'hDEAD_BEE0;
      tick;
      chk({tag, ".bread"}, 32'(bmem_read), 32'd1);
      chk({tag, ".baddr"}, bmem_addr, {addr[31:5], 5'b0});
      tick;
      chk({tag, ".bread_hold"}, 32'(bmem_read), 32'd1);
      chk({tag, ".no_resp_fill"}, 32'(imem_resp), 32'd0);
      bmem_rdata = line;
      bmem_resp  = 1'b1;
      tick;
      bmem_resp  = 1'b0;
      chk({tag, ".resp"}, 32'(imem_resp), 32'd1);
      chk({tag, ".rdata"}, imem_rdata, exp_word);
      chk({tag, ".bread_drop"}, 32'(bmem_read), 32'd0);
      tick;
      chk({tag, ".resp_end"}, 32'(imem_resp), 32'd0);
   endtask

   task automatic fetch_hit(input string tag, input logic [31:0] addr, input logic [31:0] exp_word);
      imem_addr  = addr;
      imem_rmask = 4'hF;
      tick;
      chk({tag, ".resp"}, 32'(imem_resp), 32'd1);
      chk({tag, ".rdata"}, imem_rdata, exp_word);
      chk({tag, ".bread"}, 32'(bmem_read), 32'd0);
   endtask

   task automatic idle_req(input string tag);
      imem_rmask = 4'h0;
      tick;
      chk({tag, ".resp_end"}, 32'(imem_resp), 32'd0);
      chk({tag, ".bread"}, 32'(bmem_read), 32'd0);
   endtask

   logic [255:0] line_a;
   logic [255:0] line_b;
   logic [255:0] line_c;
   logic [255:0] line_d;

   initial begin
      rst        = 1'b0;
      imem_addr  = '0;
      imem_rmask = '0;
      flush      = 1'b0;
      bmem_rdata = '0;
      bmem_resp  = 1'b0;
      line_a     = mk_line(32'h6000_0000);
      line_a[63:32] = 32'h0000_0013;
      line_b     = mk_line(32'h6000_0200);
      line_c     = mk_line(32'h6000_0400);
      line_d     = mk_line(32'h6000_0020);

      #12;
      chk("rst.imem_resp", 32'(imem_resp), 32'd0);
      chk("rst.imem_rdata", imem_rdata, 32'd0);
      chk("rst.bmem_read", 32'(bmem_read), 32'd0);
      chk("rst.bmem_addr", bmem_addr, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      tick;

      fetch_miss("cold", 32'h6000_0004, line_a, 32'h0000_0013);

      // back-to-back hits on the filled line
      fetch_hit("hit0", 32'h6000_0000, 32'hDEEF_0000);
      fetch_hit("hit8", 32'h6000_0008, 32'hDEEF_0008);
      fetch_hit("hit1c", 32'h6000_001C, 32'hDEEF_001C);
      idle_req("hitstream");

      // conflict on index 0 evicts and refills
      fetch_miss("conf_b", 32'h6000_0200, line_b, 32'hDEEF_0200);
      fetch_hit("conf_b_hit", 32'h6000_0204, 32'hDEEF_0204);
      idle_req("conf_b_hit");
      fetch_miss("conf_a", 32'h6000_0000, line_a, 32'hDEEF_0000);

      // flush during fill: data returned, line not installed
      imem_addr  = 32'h6000_0408;
      imem_rmask = 4'hF;
      tick;
      chk("ffill.cmp_resp", 32'(imem_resp), 32'd0);
      imem_rmask = 4'h0;
      tick;
      chk("ffill.bread", 32'(bmem_read), 32'd1);
      flush = 1'b1;
      tick;
      flush = 1'b0;
      chk("ffill.bread_hold", 32'(bmem_read), 32'd1);
      bmem_rdata = line_c;
      bmem_resp  = 1'b1;
      tick;
      bmem_resp  = 1'b0;
      chk("ffill.resp", 32'(imem_resp), 32'd1);
      chk("ffill.rdata", imem_rdata, 32'hDEEF_0408);
      tick;
      chk("ffill.resp_once", 32'(imem_resp), 32'd0);
      fetch_miss("ffill_re", 32'h6000_0408, line_c, 32'hDEEF_0408);
      fetch_hit("ffill_hit", 32'h6000_0410, 32'hDEEF_0410);
      idle_req("ffill_hit");

      // flush coincident with bmem_resp: line not installed
      imem_addr  = 32'h6000_0024;
      imem_rmask = 4'hF;
      tick;
      imem_rmask = 4'h0;
      tick;
      chk("fresp.bread", 32'(bmem_read), 32'd1);
      flush      = 1'b1;
      bmem_rdata = line_d;
      bmem_resp  = 1'b1;
      tick;
      flush      = 1'b0;
      bmem_resp  = 1'b0;
      chk("fresp.resp", 32'(imem_resp), 32'd1);
      chk("fresp.rdata", imem_rdata, 32'hDEEF_0024);
      tick;
      fetch_miss("fresp_re", 32'h6000_0024, line_d, 32'hDEEF_0024);

      // flush in the acceptance cycle hides the line from that request
      fetch_hit("pre_flush_hit", 32'h6000_0028, 32'hDEEF_0028);
      idle_req("pre_flush_hit");
      flush = 1'b1;
      fetch_miss("flush_acc", 32'h6000_0028, line_d, 32'hDEEF_0028);

      // async reset mid-fill, then a stray bmem_resp
      imem_addr  = 32'h6000_0040;
      imem_rmask = 4'hF;
      tick;
      imem_rmask = 4'h0;
      tick;
      chk("arst.bread_pre", 32'(bmem_read), 32'd1);
      #2;
      rst = 1'b0;
      #1;
      chk("arst.bread_drop", 32'(bmem_read), 32'd0);
      @(negedge clk);
      rst        = 1'b1;
      bmem_rdata = mk_line(32'h6000_0040);
      bmem_resp  = 1'b1;
      tick;
      bmem_resp  = 1'b0;
      chk("arst.stray_resp", 32'(imem_resp), 32'd0);
      chk("arst.stray_bread", 32'(bmem_read), 32'd0);
      fetch_miss("arst_re", 32'h6000_0400, line_c, 32'hDEEF_0400);
      fetch_hit("perf_h1", 32'h6000_0404, 32'hDEEF_0404);
      fetch_hit("perf_h2", 32'h6000_0408, 32'hDEEF_0408);
      fetch_hit("perf_h3", 32'h6000_040C, 32'hDEEF_040C);
      idle_req("perf");
`ifdef ICACHE_PERF_CNT_EN
      chk("perf.miss_count", miss_count, 32'd1);
      chk("perf.hit_count", hit_count, 32'd3);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
